// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and limits for the LC-3 main-memory arbiter.
package lc3_mem_pkg;

  localparam int MAX_MEM_LAT = 7;
  localparam int LAT_CNT_W   = $clog2(MAX_MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester-side handshake port and single-port memory bus used by the LC-3 memory arbiter.
interface lc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

interface lc3_mem_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on a tie, or fixed debug priority; remembers the last winner.
module rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,        // [0] = CPU, [1] = DBG
  input  logic       grant_en_i,
  input  logic       fixed_prio_i,
  output req_id_t    gnt_id_o,
  output req_id_t    last_grant_o
);

  req_id_t last_grant_q, last_grant_d;

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_id_o     = CPU;
    last_grant_d = last_grant_q;
    case (req_i)
      2'b10:   gnt_id_o = DBG;
      2'b11:   gnt_id_o = (fixed_prio_i || (last_grant_q == CPU)) ? DBG : CPU;
      default: gnt_id_o = CPU;
    endcase
    if (grant_en_i) begin
      last_grant_d = gnt_id_o;
    end
  end

  // Reset to DBG so the CPU wins the first tie after reset.
  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 main memory between the CPU load/store path and the debug loader.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int DBG_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_mem_arbiter_if.slave  cpu_if,
  lc3_mem_arbiter_if.slave  dbg_if,
  lc3_mem_bus_if.master     mem_if,
  output logic              busy_o
);

  if ((MEM_LAT < 1) || (MEM_LAT > MAX_MEM_LAT)) begin : g_bad_mem_lat
    $error("lc3_mem_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MAX_MEM_LAT);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t           state_q, state_d;
  req_id_t              id_q, id_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]    dbg_rdata_q, dbg_rdata_d;

  req_id_t gnt_id;
  req_id_t unused_last_grant;
  logic    grant_en;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        ({dbg_if.req, cpu_if.req}),
    .grant_en_i   (grant_en),
    .fixed_prio_i (DBG_PRIO != 0),
    .gnt_id_o     (gnt_id),
    .last_grant_o (unused_last_grant)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_en    = 1'b0;

    case (state_q)
      IDLE: begin
        // Requests are only looked at here; the winner's transaction is frozen until ACK.
        if (cpu_if.req || dbg_if.req) begin
          grant_en = 1'b1;
          id_d     = gnt_id;
          if (gnt_id == DBG) begin
            we_d    = dbg_if.we;
            addr_d  = dbg_if.addr;
            wdata_d = dbg_if.wdata;
          end else begin
            we_d    = cpu_if.we;
            addr_d  = cpu_if.addr;
            wdata_d = cpu_if.wdata;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = WAIT;
      end

      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (id_q == DBG) dbg_rdata_d = mem_if.rdata;
            else             cpu_rdata_d = mem_if.rdata;
          end
          state_d = ACK;
        end
      end

      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory-side outputs are decoded from registered state only, so they are glitch-free at the macro.
  assign mem_if.en    = (state_q == ISSUE);
  assign mem_if.we    = (state_q == ISSUE) && we_q;
  assign mem_if.addr  = (state_q != IDLE) ? addr_q  : '0;
  assign mem_if.wdata = (state_q != IDLE) ? wdata_q : '0;

  assign cpu_if.ack   = (state_q == ACK) && (id_q == CPU);
  assign dbg_if.ack   = (state_q == ACK) && (id_q == DBG);
  assign cpu_if.rdata = cpu_rdata_q;
  assign dbg_if.rdata = dbg_rdata_q;

  assign busy_o = (state_q != IDLE);

endmodule
